// File: rtl/snake_pkg.sv
// Shared types and defaults for the snake body engine.
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_DOWN  = 2'b01,
    DIR_UP    = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } scan_state_t;

  localparam int DEFAULT_GRID_W = 16;
  localparam int DEFAULT_GRID_H = 12;

  // The encoding pairs each direction with its bitwise complement as the reverse.
  function automatic dir_t reverse_dir(input dir_t d);
    return dir_t'(~d);
  endfunction

endpackage

// File: rtl/snake_next_head.sv
// Combinational next-head calculator with off-grid detection.
// SNAKE_WRAP_EN defined: edges wrap; undefined: leaving the grid raises off_grid_o.
module snake_next_head
  import snake_pkg::*;
#(
  parameter int XW     = 4,
  parameter int YW     = 4,
  parameter int GRID_W = DEFAULT_GRID_W,
  parameter int GRID_H = DEFAULT_GRID_H
) (
  input  logic [XW-1:0] head_x_i,
  input  logic [YW-1:0] head_y_i,
  input  dir_t          dir_i,
  output logic [XW-1:0] next_x_o,
  output logic [YW-1:0] next_y_o,
  output logic          off_grid_o
);

`ifdef SNAKE_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  always_comb begin
    next_x_o   = head_x_i;
    next_y_o   = head_y_i;
    off_grid_o = 1'b0;
    case (dir_i)
      DIR_RIGHT: begin
        if (head_x_i == XW'(GRID_W - 1)) begin
          if (WRAP) next_x_o = '0;
          else      off_grid_o = 1'b1;
        end else begin
          next_x_o = head_x_i + XW'(1);
        end
      end
      DIR_LEFT: begin
        if (head_x_i == '0) begin
          if (WRAP) next_x_o = XW'(GRID_W - 1);
          else      off_grid_o = 1'b1;
        end else begin
          next_x_o = head_x_i - XW'(1);
        end
      end
      DIR_DOWN: begin
        if (head_y_i == YW'(GRID_H - 1)) begin
          if (WRAP) next_y_o = '0;
          else      off_grid_o = 1'b1;
        end else begin
          next_y_o = head_y_i + YW'(1);
        end
      end
      DIR_UP: begin
        if (head_y_i == '0) begin
          if (WRAP) next_y_o = YW'(GRID_H - 1);
          else      off_grid_o = 1'b1;
        end else begin
          next_y_o = head_y_i - YW'(1);
        end
      end
    endcase
  end

endmodule

// File: rtl/snake_body_engine.sv
// Snake body: segment registers, growth, self-collision and a frozen segment readout.
// Edge behaviour selected by SNAKE_WRAP_EN inside snake_next_head.
module snake_body_engine
  import snake_pkg::*;
#(
  parameter int MAX_LEN  = 8,
  parameter int INIT_LEN = 3,
  parameter int GRID_W   = DEFAULT_GRID_W,
  parameter int GRID_H   = DEFAULT_GRID_H,
  parameter int XW       = 4,
  parameter int YW       = 4,
  parameter int START_X  = 7,
  parameter int START_Y  = 5
) (
  input  logic                           CLOCK_50,
  input  logic                           Resetn,
  input  logic                           init,
  input  logic                           step,
  input  logic [1:0]                     dir,
  input  logic                           grow,
  input  logic                           scan_start,
  output logic [XW-1:0]                  head_x,
  output logic [YW-1:0]                  head_y,
  output logic [$clog2(MAX_LEN+1)-1:0]   length,
  output logic                           dead,
  output logic                           scan_busy,
  output logic                           seg_valid,
  output logic [XW-1:0]                  seg_x,
  output logic [YW-1:0]                  seg_y,
  output logic                           seg_last
);

  localparam int LW = $clog2(MAX_LEN + 1);

  logic load_start;
  scan_state_t state_q, state_d;
  logic [LW-1:0] idx_q, idx_d;
  dir_t dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic [LW-1:0] len_q, len_d;
  logic dead_q, dead_d, grow_q, grow_d, pend_q, pend_d;
  logic [XW-1:0] seg_x_q [MAX_LEN];
  logic [YW-1:0] seg_y_q [MAX_LEN];

  logic scanning, req, apply, die, move;
  dir_t req_dir, new_dir;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;
  logic off_grid;
  logic [MAX_LEN-1:0] hit;

  assign load_start = !Resetn || init;
  assign scanning   = (state_q == SCAN);
  assign req        = step && !dead_q;
  // A step held during a scan replays in the first idle cycle, with the direction it arrived with.
  assign apply      = !scanning && !dead_q && (req || pend_q);
  assign req_dir    = pend_q ? pend_dir_q : dir_t'(dir);
  assign new_dir    = (req_dir == reverse_dir(dir_q)) ? dir_q : req_dir;

  snake_next_head #(
    .XW(XW), .YW(YW), .GRID_W(GRID_W), .GRID_H(GRID_H)
  ) u_next_head (
    .head_x_i  (seg_x_q[0]),
    .head_y_i  (seg_y_q[0]),
    .dir_i     (new_dir),
    .next_x_o  (nx),
    .next_y_o  (ny),
    .off_grid_o(off_grid)
  );

  // The tail only counts as an obstacle when it will not move away, i.e. while growing.
  for (genvar gi = 0; gi < MAX_LEN; gi++) begin : g_hit
    assign hit[gi] = (seg_x_q[gi] == nx) && (seg_y_q[gi] == ny) &&
                     ((LW'(gi + 1) < len_q) || (grow_q && (LW'(gi + 1) == len_q)));
  end

  assign die  = apply && (off_grid || (|hit));
  assign move = apply && !die;

  always_comb begin
    dir_d      = dir_q;
    len_d      = len_q;
    dead_d     = dead_q;
    grow_d     = grow_q;
    pend_d     = pend_q;
    pend_dir_d = pend_dir_q;
    if (scanning && req && !pend_q) begin
      pend_d     = 1'b1;
      pend_dir_d = dir_t'(dir);
    end
    if (apply) pend_d = 1'b0;
    if (move) begin
      dir_d  = new_dir;
      grow_d = 1'b0;
      if (grow_q && (len_q < LW'(MAX_LEN))) len_d = len_q + LW'(1);
    end
    if (die) dead_d = 1'b1;
    if (grow && !dead_q) grow_d = 1'b1;
  end

  always_ff @(posedge CLOCK_50) begin
    if (load_start) begin
      dir_q      <= DIR_RIGHT;
      pend_dir_q <= DIR_RIGHT;
      len_q      <= LW'(INIT_LEN);
      dead_q     <= 1'b0;
      grow_q     <= 1'b0;
      pend_q     <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < INIT_LEN) ? XW'(START_X - i) : '0;
        seg_y_q[i] <= (i < INIT_LEN) ? YW'(START_Y) : '0;
      end
    end else begin
      dir_q      <= dir_d;
      pend_dir_q <= pend_dir_d;
      len_q      <= len_d;
      dead_q     <= dead_d;
      grow_q     <= grow_d;
      pend_q     <= pend_d;
      if (move) begin
        seg_x_q[0] <= nx;
        seg_y_q[0] <= ny;
        for (int i = 1; i < MAX_LEN; i++) begin
          seg_x_q[i] <= seg_x_q[i-1];
          seg_y_q[i] <= seg_y_q[i-1];
        end
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (load_start) begin
      state_q <= IDLE;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    seg_valid = 1'b0;
    seg_x     = '0;
    seg_y     = '0;
    seg_last  = 1'b0;
    case (state_q)
      IDLE: begin
        if (scan_start) begin
          state_d = SCAN;
          idx_d   = '0;
        end
      end
      SCAN: begin
        seg_valid = 1'b1;
        seg_last  = (idx_q == len_q - LW'(1));
        for (int i = 0; i < MAX_LEN; i++) begin
          if (idx_q == LW'(i)) begin
            seg_x = seg_x_q[i];
            seg_y = seg_y_q[i];
          end
        end
        if (seg_last) begin
          state_d = IDLE;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + LW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign head_x    = seg_x_q[0];
  assign head_y    = seg_y_q[0];
  assign length    = len_q;
  assign dead      = dead_q;
  assign scan_busy = scanning;

endmodule

// File: tb/tb_snake_body_engine.sv
// Scoreboard bench for snake_body_engine: queue-based snake model, directed and random moves.
module tb_snake_body_engine;

  localparam int MAX_LEN  = 8;
  localparam int INIT_LEN = 3;
  localparam int GRID_W   = 16;
  localparam int GRID_H   = 12;
  localparam int SX       = 7;
  localparam int SY       = 5;

  logic       CLOCK_50 = 1'b0;
  logic       Resetn = 1'b0, init = 1'b0, step = 1'b0, grow = 1'b0, scan_start = 1'b0;
  logic [1:0] dir = 2'b00;
  logic [3:0] head_x, seg_x;
  logic [3:0] head_y, seg_y;
  logic [3:0] length;
  logic       dead, scan_busy, seg_valid, seg_last;

  snake_body_engine dut (
    .CLOCK_50(CLOCK_50), .Resetn(Resetn), .init(init), .step(step), .dir(dir),
    .grow(grow), .scan_start(scan_start), .head_x(head_x), .head_y(head_y),
    .length(length), .dead(dead), .scan_busy(scan_busy), .seg_valid(seg_valid),
    .seg_x(seg_x), .seg_y(seg_y), .seg_last(seg_last)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {int x; int y; bit last;} beat_t;
  beat_t exp_q[$];
  beat_t mon_e;
  int n_cmp = 0;
  int n_err = 0;

  // Model: body as coordinate queues, head at index 0.
  int bx[$];
  int by[$];
  int m_len, m_dir;
  bit m_dead, m_grow;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  always @(negedge CLOCK_50) begin
    if (seg_valid) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL seg_unexpected: got (%0d,%0d) required no beat", seg_x, seg_y);
      end else begin
        mon_e = exp_q.pop_front();
        $display("beat (%0d,%0d) last=%0d", seg_x, seg_y, seg_last);
        chk("seg_x", int'(seg_x), mon_e.x);
        chk("seg_y", int'(seg_y), mon_e.y);
        chk("seg_last", int'(seg_last), int'(mon_e.last));
      end
    end else begin
      chk("seg_idle_zero", int'({seg_x, seg_y, seg_last}), 0);
    end
  end

  task automatic m_reset();
    bx.delete();
    by.delete();
    for (int i = 0; i < INIT_LEN; i++) begin
      bx.push_back(SX - i);
      by.push_back(SY);
    end
    m_len = INIT_LEN; m_dir = 0; m_dead = 0; m_grow = 0;
  endtask

  task automatic m_step(input int d);
    int nd, nx, ny, lim;
    bit off, hit;
    if (m_dead) return;
    nd = (d == 3 - m_dir) ? m_dir : d;
    nx = bx[0];
    ny = by[0];
    case (nd)
      0: nx = nx + 1;
      1: ny = ny + 1;
      2: ny = ny - 1;
      default: nx = nx - 1;
    endcase
    off = (nx < 0) || (nx >= GRID_W) || (ny < 0) || (ny >= GRID_H);
`ifdef SNAKE_WRAP_EN
    nx = (nx + GRID_W) % GRID_W;
    ny = (ny + GRID_H) % GRID_H;
    off = 0;
`endif
    lim = m_len - 1 + (m_grow ? 1 : 0);
    hit = 0;
    for (int i = 0; i < lim; i++)
      if (bx[i] == nx && by[i] == ny) hit = 1;
    if (off || hit) begin
      m_dead = 1;
      return;
    end
    bx.push_front(nx);
    by.push_front(ny);
    if (m_grow && m_len < MAX_LEN) m_len++;
    while (bx.size() > m_len) begin
      void'(bx.pop_back());
      void'(by.pop_back());
    end
    m_grow = 0;
    m_dir = nd;
  endtask

  task automatic tick();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic check_state(input string tag);
    $display("%s: head=(%0d,%0d) len=%0d dead=%0d", tag, head_x, head_y, length, dead);
    chk({tag, "_head_x"}, int'(head_x), bx[0]);
    chk({tag, "_head_y"}, int'(head_y), by[0]);
    chk({tag, "_length"}, int'(length), m_len);
    chk({tag, "_dead"}, int'(dead), int'(m_dead));
    chk({tag, "_busy"}, int'(scan_busy), 0);
  endtask

  task automatic do_step(input int d, input bit g);
    dir = 2'(d); step = 1'b1; grow = g;
    tick();
    step = 1'b0; grow = 1'b0;
    m_step(d);
    if (g && !m_dead) m_grow = 1;
  endtask

  task automatic do_grow();
    grow = 1'b1;
    tick();
    grow = 1'b0;
    if (!m_dead) m_grow = 1;
  endtask

  task automatic do_init(input bit with_step);
    init = 1'b1; step = with_step; dir = 2'($urandom_range(0, 3));
    tick();
    init = 1'b0; step = 1'b0;
    m_reset();
  endtask

  task automatic push_scan();
    for (int i = 0; i < m_len; i++) begin
      beat_t b;
      b.x = bx[i]; b.y = by[i]; b.last = (i == m_len - 1);
      exp_q.push_back(b);
    end
  endtask

  // step_beat < 0: no step; otherwise step on that beat and the next (second one must drop).
  task automatic do_scan(input int step_beat, input int sdir);
    int busy;
    bit stepped;
    push_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    busy = 0;
    stepped = 0;
    for (int c = 0; c < MAX_LEN + 2 && scan_busy; c++) begin
      busy++;
      if (step_beat >= 0 && (c == step_beat || c == step_beat + 1)) begin
        step = 1'b1; dir = 2'(sdir); stepped = 1;
      end
      tick();
      step = 1'b0;
    end
    chk("scan_busy_cycles", busy, m_len);
    chk("scan_drained", exp_q.size(), 0);
    if (stepped) begin
      chk("pend_hold_x", int'(head_x), bx[0]);
      chk("pend_hold_y", int'(head_y), by[0]);
      tick();
      m_step(sdir);
    end
    check_state("scan_post");
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  initial begin
    tick();
    tick();
    Resetn = 1'b1;
    m_reset();
    check_state("reset");

    do_scan(-1, 0);

    do_step(1, 0);
    chk("turn_down_y", int'(head_y), 6);
    do_step(2, 0);
    chk("reverse_ignored_y", int'(head_y), 7);
    chk("reverse_ignored_x", int'(head_x), 7);
    check_state("turns");

    do_init(0);
    do_grow();
    for (int k = 0; k < 6; k++) begin
      do_step(0, 0);
      chk("grow_len", int'(length), 4);
    end
    check_state("grow_right");

    do_init(0);
    for (int k = 0; k < 8; k++) do_step(0, 0);
    chk("at_wall_x", int'(head_x), 15);
    do_step(0, 0);
`ifdef SNAKE_WRAP_EN
    chk("wrap_x", int'(head_x), 0);
    chk("wrap_dead", int'(dead), 0);
`else
    chk("wall_dead", int'(dead), 1);
    chk("wall_hold_x", int'(head_x), 15);
    do_step(1, 0);
    chk("dead_frozen_y", int'(head_y), 5);
`endif
    check_state("wall");

    do_init(0);
    do_grow(); do_step(0, 0);
    do_grow(); do_step(0, 0);
    chk("len5", int'(length), 5);
    do_step(1, 0);
    do_step(3, 0);
    do_step(2, 0);
    chk("collide_dead", int'(dead), 1);
    chk("collide_frozen_x", int'(head_x), 8);
    chk("collide_frozen_y", int'(head_y), 6);
    check_state("collide");
    do_init(0);
    chk("init_clears_dead", int'(dead), 0);
    chk("init_len", int'(length), 3);

    do_scan(0, 1);
    do_scan(2, 0);

    do_step(0, 0);
    do_init(1);
    check_state("init_with_step");

    push_scan();
    scan_start = 1'b1;
    tick();
    scan_start = 1'b0;
    Resetn = 1'b0;
    tick();
    Resetn = 1'b1;
    exp_q.delete();
    m_reset();
    check_state("reset_mid_scan");

    for (int k = 0; k < 8; k++) begin
      do_grow();
      do_step((k % 2) ? 0 : 1, 0);
    end
    chk("saturated_len", int'(length), MAX_LEN);
    check_state("saturate");

    for (int it = 0; it < 400; it++) begin
      int r;
      r = $urandom_range(0, 9);
      if (m_dead && $urandom_range(0, 2) == 0) do_init($urandom_range(0, 1) == 1);
      else if (r <= 5) do_step($urandom_range(0, 3), r == 5);
      else if (r <= 7) do_grow();
      else if (r == 8) do_scan($urandom_range(0, 1) ? -1 : $urandom_range(0, m_len - 1), $urandom_range(0, 3));
      else do_init(1);
      check_state("rand");
    end

    tick();
    tick();
    chk("final_queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
